id_stage_pipelined: RTL and testbench

//  Parametrised decode stage. Holds the IF/ID pipeline register with a valid/ready handshake,

---
 rtl/id_stage_pipelined.sv | 187 ++++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// Decode stage: IF/ID register with valid/ready handshake, register file, control decode and load-use hazard detection.
// Optional build macro ID_WB_BYPASS_EN forwards same-cycle write-back data onto the register reads.
module id_stage_pipelined #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           instruction_in,
  input  logic [XLEN-1:0]       PCPlus4_in,
  input  logic                  flush,
  input  logic                  ex_ready,
  input  logic                  ex_MemtoReg,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  id_valid,
  output logic [XLEN-1:0]       PCPlus4_out,
  output logic [XLEN-1:0]       rs_reg,
  output logic [XLEN-1:0]       rt_reg,
  output logic [REG_ADDR_W-1:0] rs_addr_out,
  output logic [REG_ADDR_W-1:0] rt_addr_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [4:0]            shamt_out,
  output logic [25:0]           address_Jtype_out,
  output logic [XLEN-1:0]       imm_signExtended,
  output logic [XLEN-1:0]       imm_zeroExtended,
  output logic                  RegWriteD,
  output logic                  MemtoRegD,
  output logic                  MemWriteD,
  output logic                  BranchD,
  output logic                  JumpD,
  output logic                  RegDstD,
  output logic [5:0]            ALUopD,
  output logic [5:0]            ALUfunctD,
  output logic                  illegal_out
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2A;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic branch;
    logic jump;
    logic reg_dst;
    logic illegal;
  } ctrl_t;

  logic                  valid_q, valid_d;
  logic [31:0]           instr_q, instr_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       regs_q [NREGS];
  logic                  hazard;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
  ctrl_t                 dec;

  assign rs_addr = instr_q[21 +: REG_ADDR_W];
  assign rt_addr = instr_q[16 +: REG_ADDR_W];
  assign rd_addr = instr_q[11 +: REG_ADDR_W];

  // Load-use: the load in EX has not produced its data yet, so ID must hold and emit bubbles.
  assign hazard   = valid_q && ex_MemtoReg && (ex_rt_addr != '0)
                    && ((ex_rt_addr == rs_addr) || (ex_rt_addr == rt_addr));
  assign if_ready = !valid_q || (ex_ready && !hazard);
  assign id_valid = valid_q && !hazard;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (if_ready) begin
      valid_d = if_valid;
      instr_d = instruction_in;
      pc_d    = PCPlus4_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign wb_en = RegWriteW && !(R0_HARDWIRED && (wb_addr == '0));

  // NOTE: the register file is reset explicitly because software may read registers before writing them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [REG_ADDR_W-1:0] addr);
    logic [XLEN-1:0] data;
    data = regs_q[addr];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_addr == addr)) data = wb_data;
`endif
    if (R0_HARDWIRED && (addr == '0)) data = '0;
    return data;
  endfunction

  assign rs_reg = rf_read(rs_addr);
  assign rt_reg = rf_read(rt_addr);

  always_comb begin
    dec = '0;
    case (instr_q[31:26])
      OP_RTYPE: begin
        case (instr_q[5:0])
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT,
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
          end
          FN_JR:   dec.jump    = 1'b1;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: dec.reg_write = 1'b1;
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SW:         dec.mem_write = 1'b1;
      OP_BEQ, OP_BNE: dec.branch   = 1'b1;
      OP_J:          dec.jump      = 1'b1;
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default:       dec.illegal   = 1'b1;
    endcase
  end

  // Side-effecting controls are killed on bubbles; the rest only need to be quiet when ID is empty.
  assign RegWriteD   = dec.reg_write  && id_valid;
  assign MemWriteD   = dec.mem_write  && id_valid;
  assign BranchD     = dec.branch     && id_valid;
  assign JumpD       = dec.jump       && id_valid;
  assign MemtoRegD   = dec.mem_to_reg && valid_q;
  assign RegDstD     = dec.reg_dst    && valid_q;
  assign illegal_out = dec.illegal    && valid_q;

  assign PCPlus4_out       = pc_q;
  assign rs_addr_out       = rs_addr;
  assign rt_addr_out       = rt_addr;
  assign rd_addr_out       = rd_addr;
  assign shamt_out         = instr_q[10:6];
  assign address_Jtype_out = instr_q[25:0];
  assign imm_signExtended  = {{(XLEN-16){instr_q[15]}}, instr_q[15:0]};
  assign imm_zeroExtended  = {{(XLEN-16){1'b0}}, instr_q[15:0]};
  assign ALUopD            = instr_q[31:26];
  assign ALUfunctD         = instr_q[5:0];

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed self-checking bench for id_stage_pipelined: reset, register file, hazard, stall/flush and decode.
module tb_id_stage_pipelined;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_valid, if_ready;
  logic [31:0] instruction_in, PCPlus4_in;
  logic        flush, ex_ready, ex_MemtoReg;
  logic [4:0]  ex_rt_addr;
  logic        RegWriteW;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] PCPlus4_out, rs_reg, rt_reg;
  logic [4:0]  rs_addr_out, rt_addr_out, rd_addr_out, shamt_out;
  logic [25:0] address_Jtype_out;
  logic [31:0] imm_signExtended, imm_zeroExtended;
  logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD;
  logic [5:0]  ALUopD, ALUfunctD;
  logic        illegal_out;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage_pipelined dut (
    .CLK(CLK), .RST(RST),
    .if_valid(if_valid), .if_ready(if_ready),
    .instruction_in(instruction_in), .PCPlus4_in(PCPlus4_in),
    .flush(flush), .ex_ready(ex_ready),
    .ex_MemtoReg(ex_MemtoReg), .ex_rt_addr(ex_rt_addr),
    .RegWriteW(RegWriteW), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .PCPlus4_out(PCPlus4_out),
    .rs_reg(rs_reg), .rt_reg(rt_reg),
    .rs_addr_out(rs_addr_out), .rt_addr_out(rt_addr_out), .rd_addr_out(rd_addr_out),
    .shamt_out(shamt_out), .address_Jtype_out(address_Jtype_out),
    .imm_signExtended(imm_signExtended), .imm_zeroExtended(imm_zeroExtended),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .RegDstD(RegDstD),
    .ALUopD(ALUopD), .ALUfunctD(ALUfunctD), .illegal_out(illegal_out)
  );

  always #5 CLK = ~CLK;

  task automatic load_instr(input logic [31:0] instr, input logic [31:0] pc);
    flush = 1'b0; ex_MemtoReg = 1'b0; ex_ready = 1'b1;
    if_valid = 1'b1; instruction_in = instr; PCPlus4_in = pc;
    @(posedge CLK); #1;
    if_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    RegWriteW = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge CLK); #1;
    RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    wb_write(5'd5, 32'h5555_AAAA);
    wb_write(5'd31, 32'h3131_3131);
    load_instr(32'h03E5_1820, 32'h0000_0044);
    ex_ready = 1'b0; if_valid = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1; #1;
    n_tests++;
    if ({id_valid, if_ready, illegal_out, RegDstD, MemtoRegD} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 01000", {id_valid, if_ready, illegal_out, RegDstD, MemtoRegD});
    end
    n_tests++;
    if (PCPlus4_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected 0", PCPlus4_out);
    end
    @(posedge CLK); #1;
    RST = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = 5'(i);
      load_instr({6'h00, a, a, 5'd1, 5'd0, 6'h20}, 32'h0);
      n_tests++;
      if ({rs_reg, rt_reg} !== 64'h0) begin
        n_fail++; $display("FAIL reset_reg%0d: got rs=%h rt=%h expected 0", i, rs_reg, rt_reg);
      end
    end
  endtask

  task automatic test_add();
    wb_write(5'd5, 32'hDEAD_BEEF);
    load_instr(32'h00A5_1820, 32'h0000_0008);
    n_tests++;
    if ({rs_reg, rt_reg} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL add_read: got rs=%h rt=%h expected deadbeef", rs_reg, rt_reg);
    end
    n_tests++;
    if ({id_valid, RegWriteD, RegDstD, rd_addr_out, PCPlus4_out} !== {3'b111, 5'd3, 32'h8}) begin
      n_fail++; $display("FAIL add_ctrl: got v=%b rw=%b rd=%b dst=%0d pc=%h expected 1 1 1 3 8",
                         id_valid, RegWriteD, RegDstD, rd_addr_out, PCPlus4_out);
    end
  endtask

  task automatic test_r0_bypass();
    logic [31:0] exp_same;
    wb_write(5'd0, 32'h0000_1234);
    load_instr(32'h0007_0820, 32'h0000_000C);
    n_tests++;
    if (rs_reg !== 32'h0) begin
      n_fail++; $display("FAIL r0_read: got %h expected 0", rs_reg);
    end
`ifdef ID_WB_BYPASS_EN
    exp_same = 32'hCAFE_0007;
`else
    exp_same = 32'h0;
`endif
    RegWriteW = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE_0007; #1;
    n_tests++;
    if (rt_reg !== exp_same) begin
      n_fail++; $display("FAIL r7_same_cycle: got %h expected %h", rt_reg, exp_same);
    end
    @(posedge CLK); #1;
    RegWriteW = 1'b0; #1;
    n_tests++;
    if (rt_reg !== 32'hCAFE_0007) begin
      n_fail++; $display("FAIL r7_next_cycle: got %h expected cafe0007", rt_reg);
    end
  endtask

  task automatic test_hazard();
    load_instr(32'h0081_1020, 32'h0000_0100);
    ex_MemtoReg = 1'b1; ex_rt_addr = 5'd4;
    if_valid = 1'b1; instruction_in = 32'h0022_1804; PCPlus4_in = 32'h0000_0104; #1;
    n_tests++;
    if ({id_valid, if_ready, RegWriteD} !== 3'b000) begin
      n_fail++; $display("FAIL hazard_rs: got v=%b rdy=%b rw=%b expected 000", id_valid, if_ready, RegWriteD);
    end
    @(posedge CLK); #1;
    n_tests++;
    if ({rs_addr_out, rt_addr_out, rd_addr_out, PCPlus4_out, id_valid} !== {5'd4, 5'd1, 5'd2, 32'h100, 1'b0}) begin
      n_fail++; $display("FAIL hazard_hold: got rs=%0d rt=%0d rd=%0d pc=%h v=%b expected 4 1 2 100 0",
                         rs_addr_out, rt_addr_out, rd_addr_out, PCPlus4_out, id_valid);
    end
    ex_rt_addr = 5'd1; #1;
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL hazard_rt: got %b expected 0", id_valid);
    end
    ex_rt_addr = 5'd0; #1;
    n_tests++;
    if ({id_valid, if_ready} !== 2'b11) begin
      n_fail++; $display("FAIL hazard_r0: got %b expected 11", {id_valid, if_ready});
    end
    ex_rt_addr = 5'd4; ex_MemtoReg = 1'b0; #1;
    n_tests++;
    if ({id_valid, if_ready, RegWriteD, rd_addr_out} !== {3'b111, 5'd2}) begin
      n_fail++; $display("FAIL hazard_release: got v=%b rdy=%b rw=%b rd=%0d expected 1 1 1 2",
                         id_valid, if_ready, RegWriteD, rd_addr_out);
    end
    load_instr(32'h0081_1020, 32'h0000_0200);
    ex_MemtoReg = 1'b1; ex_rt_addr = 5'd4; flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0; ex_MemtoReg = 1'b0; #1;
    n_tests++;
    if ({id_valid, if_ready} !== 2'b01) begin
      n_fail++; $display("FAIL hazard_flush: got %b expected 01", {id_valid, if_ready});
    end
  endtask

  task automatic test_stall_flush();
    load_instr(32'h00A5_1820, 32'h0000_0200);
    ex_ready = 1'b0; if_valid = 1'b1; instruction_in = 32'h8C22_0004; PCPlus4_in = 32'h0000_0300;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      n_tests++;
      if ({if_ready, id_valid, PCPlus4_out, ALUopD, rd_addr_out} !== {2'b01, 32'h200, 6'h00, 5'd3}) begin
        n_fail++; $display("FAIL stall_c%0d: got rdy=%b v=%b pc=%h op=%h rd=%0d expected 0 1 200 00 3",
                           c, if_ready, id_valid, PCPlus4_out, ALUopD, rd_addr_out);
      end
    end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0; if_valid = 1'b0; #1;
    n_tests++;
    if ({id_valid, if_ready, RegWriteD} !== 3'b010) begin
      n_fail++; $display("FAIL stall_flush: got %b expected 010", {id_valid, if_ready, RegWriteD});
    end
    ex_ready = 1'b1;
  endtask

  task automatic test_decode();
    // expected {RegWrite, MemtoReg, MemWrite, Branch, Jump, RegDst, illegal}
    logic [31:0] instr_tab [11] = '{32'hFC00_0000, 32'h2001_8000, 32'h8C22_0004, 32'hAC22_0004,
                                    32'h1022_0004, 32'h1422_0004, 32'h0800_0010, 32'h0C00_0010,
                                    32'h03E0_0008, 32'h3422_0004, 32'h0022_1801};
    logic [6:0]  exp_tab   [11] = '{7'b0000001, 7'b1000000, 7'b1100000, 7'b0010000,
                                    7'b0001000, 7'b0001000, 7'b0000100, 7'b1000100,
                                    7'b0000100, 7'b1000000, 7'b0000001};
    for (int i = 0; i < 11; i++) begin
      load_instr(instr_tab[i], 32'h0000_0400);
      n_tests++;
      if ({RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD, illegal_out} !== exp_tab[i]) begin
        n_fail++; $display("FAIL decode_%h: got %b expected %b", instr_tab[i],
                           {RegWriteD, MemtoRegD, MemWriteD, BranchD, JumpD, RegDstD, illegal_out}, exp_tab[i]);
      end
    end
    load_instr(32'h2001_8000, 32'h0000_0500);
    n_tests++;
    if ({imm_signExtended, imm_zeroExtended} !== {32'hFFFF_8000, 32'h0000_8000}) begin
      n_fail++; $display("FAIL imm_ext: got s=%h z=%h expected ffff8000 00008000",
                         imm_signExtended, imm_zeroExtended);
    end
    load_instr(32'h0C12_3456, 32'h0000_0600);
    n_tests++;
    if ({address_Jtype_out, ALUopD} !== {26'h012_3456, 6'h03}) begin
      n_fail++; $display("FAIL jfield: got addr=%h op=%h expected 0123456 03", address_Jtype_out, ALUopD);
    end
    load_instr(32'h0002_1943, 32'h0000_0700);
    n_tests++;
    if ({shamt_out, ALUfunctD, RegDstD} !== {5'd5, 6'h03, 1'b1}) begin
      n_fail++; $display("FAIL sra_fields: got sh=%0d fn=%h dst=%b expected 5 03 1", shamt_out, ALUfunctD, RegDstD);
    end
  endtask

  initial begin
    RST = 1'b1; if_valid = 1'b0; instruction_in = '0; PCPlus4_in = '0;
    flush = 1'b0; ex_ready = 1'b1; ex_MemtoReg = 1'b0; ex_rt_addr = '0;
    RegWriteW = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    test_reset();
    test_add();
    test_r0_bypass();
    test_hazard();
    test_stall_flush();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
